// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 8;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - request/grant/response data memory bus
interface lsu_bus_if;
    import lsu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select with sign/zero extension
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_en;

    assign byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign sign_en   = ~funct3_i[2];

    // Pick the addressed lane and extend it; word (and reserved size) passes through
    always_comb begin
        data_o = rdata_i;
        case (funct3_i[1:0])
            LS_B:    data_o = {{24{byte_lane[7] & sign_en}}, byte_lane};
            LS_H:    data_o = {{16{half_lane[15] & sign_en}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with one outstanding bus transaction
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_W-1:0]     alu_y,
    input  logic [DATA_W-1:0]     rdd2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  stall,
    lsu_bus_if.master             bus,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  misaligned,
    output logic                  bus_err
);

    lsu_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  mem_we_q;
    logic [DATA_W-1:0]     mem_addr_q;
    logic [3:0]            mem_be_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    logic                  wb_valid_q, wb_we_q, mis_q, err_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]     wb_data_q;

    logic                  is_mem, mis_c, timeout_hit;
    logic [3:0]            be_c;
    logic [DATA_W-1:0]     wdata_c, load_data;

    logic                  wb_fire, wb_we_d, mis_d, err_d;
    logic [REG_ADDR_W-1:0] wb_rd_d;
    logic [DATA_W-1:0]     wb_data_d;

    assign is_mem      = mem_read | mem_write;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_load_align u_align (
        .rdata_i  (bus.mem_rdata),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // Alignment, byte strobes and lane replication from the EX operands
    always_comb begin
        mis_c   = 1'b0;
        be_c    = 4'b1111;
        wdata_c = rdd2;
        case (funct3[1:0])
            LS_B: begin
                be_c    = 4'b0001 << alu_y[1:0];
                wdata_c = {4{rdd2[7:0]}};
            end
            LS_H: begin
                mis_c   = alu_y[0];
                be_c    = 4'b0011 << alu_y[1:0];
                wdata_c = {2{rdd2[15:0]}};
            end
            LS_W:    mis_c = |alu_y[1:0];
            default: mis_c = |alu_y[1:0];
        endcase
    end

    // Next state plus the writeback record to publish on the following cycle
    always_comb begin
        state_d   = state_q;
        wb_fire   = 1'b0;
        wb_we_d   = 1'b0;
        wb_rd_d   = rd_q;
        wb_data_d = '0;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    wb_rd_d = rd;
                    if (!is_mem) begin
                        wb_fire   = 1'b1;
                        wb_we_d   = (rd != '0);
                        wb_data_d = alu_y;
                    end else if (mis_c) begin
                        wb_fire = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    if (mem_we_q) begin
                        wb_fire = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_hit) begin
                    wb_fire = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    wb_fire   = 1'b1;
                    wb_we_d   = (rd_q != '0);
                    wb_data_d = load_data;
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    wb_fire = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch on accept, timeout counter and registered writeback pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            cnt_q      <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
            wb_valid_q <= wb_fire;
            wb_we_q    <= wb_we_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
            if (wb_fire) begin
                wb_rd_q   <= wb_rd_d;
                wb_data_q <= wb_data_d;
            end
            if (state_q == IDLE && ex_valid) begin
                funct3_q    <= funct3;
                off_q       <= alu_y[1:0];
                rd_q        <= rd;
                mem_we_q    <= mem_write;
                mem_addr_q  <= {alu_y[31:2], 2'b00};
                mem_be_q    <= be_c;
                mem_wdata_q <= wdata_c;
            end
        end
    end

    assign stall         = (state_q != IDLE);
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_we         = wb_we_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misaligned    = mis_q;
    assign bus_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_y, rdd2;
    logic [4:0]  rd;
    logic        stall, wb_valid, wb_we, misaligned, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    lsu_bus_if bus();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_y      (alu_y),
        .rdd2       (rdd2),
        .rd         (rd),
        .stall      (stall),
        .bus        (bus),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    // expected outputs for the current cycle
    logic        e_stall, e_req, e_we, e_wbv, e_wbwe, e_mis, e_err, e_chkd;
    logic [31:0] e_addr, e_wdata, e_wbdata;
    logic [3:0]  e_be;
    logic [4:0]  e_wbrd;
    // writeback record due on the next cycle
    logic        p_v, p_we, p_mis, p_err, p_chkd;
    logic [31:0] p_data;
    logic [4:0]  p_rd;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    int          req_cyc = 0;
    int          wb_cnt  = 0;
    logic [31:0] obs_addr, obs_wdata, obs_wbdata;
    logic [3:0]  obs_be;
    logic        obs_wbwe, obs_mis, obs_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        be = '0;
        for (int k = 0; k < nbytes(sz); k++) be[int'(off) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(sz);
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdat);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(rdat[8*(int'(off) + k) +: 8]) << (8*k);
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic set_pend(input logic we, input logic [4:0] r, input logic [31:0] d,
                            input logic chkd, input logic mis, input logic err);
        p_v = 1'b1; p_we = we; p_rd = r; p_data = d; p_chkd = chkd; p_mis = mis; p_err = err;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e_wbv = p_v; e_wbwe = p_we; e_wbrd = p_rd; e_wbdata = p_data;
        e_chkd = p_chkd; e_mis = p_mis; e_err = p_err;
        p_v = 1'b0; p_we = 1'b0; p_mis = 1'b0; p_err = 1'b0; p_chkd = 1'b0;
    endtask

    task automatic scramble();
        ex_valid  = 1'($urandom);
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        funct3    = 3'($urandom);
        alu_y     = $urandom;
        rdd2      = $urandom;
        rd        = 5'($urandom);
    endtask

    task automatic idle();
        step();
        scramble();
        ex_valid = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata = $urandom;
        e_stall = 1'b0; e_req = 1'b0;
    endtask

    task automatic settle();
        idle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_op(input logic rdn, input logic wrn, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input int gd, input int rvd, input logic [31:0] rdat);
        logic mem, st, mis;
        mem = rdn | wrn;
        st  = wrn;
        mis = mem && ((int'(a[1:0]) % nbytes(f3[1:0])) != 0);
        step();
        ex_valid = 1'b1; mem_read = rdn; mem_write = wrn; funct3 = f3;
        alu_y = a; rdd2 = d; rd = r;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
        e_stall = 1'b0; e_req = 1'b0;
        if (!mem || mis) begin
            set_pend(!mem && r != 5'd0, r, a, !mem, mis, 1'b0);
            return;
        end
        for (int i = 0; i < 100000; i++) begin
            step();
            scramble();
            e_stall = 1'b1; e_req = 1'b1; e_we = st;
            e_addr = {a[31:2], 2'b00}; e_be = m_be(f3[1:0], a[1:0]); e_wdata = m_wdata(f3[1:0], d);
            bus.mem_gnt = (i == gd); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            if (i == gd) begin
                if (st) begin
                    set_pend(1'b0, r, '0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                break;
            end
            if (i == TO - 1) begin
                set_pend(1'b0, r, '0, 1'b0, 1'b0, 1'b1);
                return;
            end
        end
        for (int j = 0; j < 100000; j++) begin
            step();
            scramble();
            e_stall = 1'b1; e_req = 1'b0;
            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = (j == rvd);
            bus.mem_rdata = (j == rvd) ? rdat : $urandom;
            if (j == rvd) begin
                set_pend(r != 5'd0, r, m_load(f3[1:0], f3[2], a[1:0], rdat), 1'b1, 1'b0, 1'b0);
                return;
            end
            if (gd + 1 + j == TO - 1) begin
                set_pend(1'b0, r, '0, 1'b0, 1'b0, 1'b1);
                return;
            end
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_stall"},      stall,         0);
        chk({pfx, "_mem_req"},    bus.mem_req,   0);
        chk({pfx, "_mem_we"},     bus.mem_we,    0);
        chk({pfx, "_mem_addr"},   bus.mem_addr,  0);
        chk({pfx, "_mem_be"},     bus.mem_be,    0);
        chk({pfx, "_mem_wdata"},  bus.mem_wdata, 0);
        chk({pfx, "_wb_valid"},   wb_valid,      0);
        chk({pfx, "_wb_we"},      wb_we,         0);
        chk({pfx, "_wb_rd"},      wb_rd,         0);
        chk({pfx, "_wb_data"},    wb_data,       0);
        chk({pfx, "_misaligned"}, misaligned,    0);
        chk({pfx, "_bus_err"},    bus_err,       0);
    endtask

    task automatic reset_in_wait();
        int wb_before;
        step();
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_y = 32'h6000; rdd2 = 32'h5555_AAAA; rd = 5'd4;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        e_stall = 1'b0; e_req = 1'b0;
        step();
        ex_valid = 1'b0; bus.mem_gnt = 1'b1;
        e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0;
        e_addr = 32'h6000; e_be = 4'hF; e_wdata = 32'h5555_AAAA;
        step();
        bus.mem_gnt = 1'b0; e_stall = 1'b1; e_req = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        e_stall = 1'b0; e_req = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("rst_wait");
        wb_before = wb_cnt;
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("rst_wait_no_wb", wb_cnt, wb_before);
    endtask

    // Per-cycle comparison against the model expectations, plus observation capture
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",      stall,       e_stall);
            chk("mem_req",    bus.mem_req, e_req);
            chk("wb_valid",   wb_valid,    e_wbv);
            chk("misaligned", misaligned,  e_mis);
            chk("bus_err",    bus_err,     e_err);
            if (e_req) begin
                chk("mem_we",    bus.mem_we,    e_we);
                chk("mem_addr",  bus.mem_addr,  e_addr);
                chk("mem_be",    bus.mem_be,    e_be);
                chk("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (e_wbv) begin
                chk("wb_we", wb_we, e_wbwe);
                if (e_wbwe) chk("wb_rd", wb_rd, e_wbrd);
                if (e_chkd) chk("wb_data", wb_data, e_wbdata);
            end
            if (bus.mem_req) begin
                req_cyc++;
                obs_addr = bus.mem_addr; obs_be = bus.mem_be; obs_wdata = bus.mem_wdata;
            end
            if (wb_valid) begin
                wb_cnt++;
                obs_wbdata = wb_data; obs_wbwe = wb_we; obs_mis = misaligned; obs_err = bus_err;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ops;
        reset = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; alu_y = '0; rdd2 = '0; rd = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_wbwe = 0; e_mis = 0; e_err = 0; e_chkd = 0;
        e_addr = '0; e_wdata = '0; e_wbdata = '0; e_be = '0; e_wbrd = '0;
        p_v = 0; p_we = 0; p_mis = 0; p_err = 0; p_chkd = 0; p_data = '0; p_rd = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        step();
        reset = 1'b1;

        do_op(1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
        settle();
        chk("nonmem_data", obs_wbdata, 32'h1234);
        chk("nonmem_we", obs_wbwe, 1);
        do_op(1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd0, 0, 0, 32'h0);
        settle();
        chk("nonmem_rd0_we", obs_wbwe, 0);

        req_cyc = 0;
        do_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAB, 5'd3, 2, 0, 32'h0);
        settle();
        chk("sb_req_cycles", req_cyc, 3);
        chk("sb_addr", obs_addr, 32'h1000);
        chk("sb_be", obs_be, 4'b1000);
        chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        chk("sb_wb_we", obs_wbwe, 0);

        do_op(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 5'd9, 0, 2, 32'h8001_0000);
        settle();
        chk("lh_data", obs_wbdata, 32'hFFFF_8001);
        do_op(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 5'd9, 1, 2, 32'h8001_0000);
        settle();
        chk("lhu_data", obs_wbdata, 32'h0000_8001);

        req_cyc = 0;
        do_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd6, 0, 0, 32'h0);
        settle();
        chk("mis_req_cycles", req_cyc, 0);
        chk("mis_flag", obs_mis, 1);
        chk("mis_we", obs_wbwe, 0);

        do_op(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd7, 100000, 0, 32'h0);
        settle();
        chk("to_req_err", obs_err, 1);
        chk("to_req_we", obs_wbwe, 0);
        idle();
        @(negedge clk);
        #1;
        chk("to_after_stall", stall, 0);
        chk("to_after_req", bus.mem_req, 0);

        do_op(1'b1, 1'b0, 3'b000, 32'h5001, 32'h0, 5'd8, 1, 100000, 32'h0);
        settle();
        chk("to_wait_err", obs_err, 1);

        reset_in_wait();

        wb_cnt = 0;
        ops = 0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  kind, sz;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = 2'($urandom);
            sz   = 2'($urandom_range(0, 2));
            f3   = {1'($urandom), sz};
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_op(kind == 2'd1 || kind == 2'd3, kind[1], f3, a, $urandom,
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            ops++;
            if ($urandom_range(0, 4) == 0) idle();
        end
        settle();
        chk("random_wb_count", wb_cnt, ops);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage that sits between the execution stage and the data memory bus. It takes the EX result (address/ALU value, store data, destination register) and runs a single outstanding request/grant/response transaction for loads and stores. It handles byte-lane alignment, store strobes and load sign/zero extension. It stalls the upstream pipeline while a transaction is in flight and delivers one writeback record per accepted instruction.

Parameters:
TIMEOUT, 255, number of cycles in REQ+WAIT without completion before bus_err is raised (8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset; sampled on posedge clk
ex_valid  in  1  EX presents an instruction
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
funct3  in  3  [1:0] size (00 B, 01 H, 10 W), [2] unsigned load
alu_y  in  `MEM_DATA_BUS  address for loads/stores; result for other instructions
rdd2  in  `MEM_DATA_BUS  store data
rd  in  `REG_ADDR_BUS  destination register
stall  out  1  hold EX; equals (state != IDLE)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address {alu_y[31:2],2'b00}
mem_be  out  4  byte strobes
mem_wdata  out  32  store data replicated across lanes
mem_gnt  in  1  bus accepted the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
wb_valid  out  1  one-cycle pulse per retired instruction
wb_we  out  1  register write enable
wb_rd  out  `REG_ADDR_BUS  destination register
wb_data  out  `REG_BUS  writeback value
misaligned  out  1  qualifies wb_valid: alignment fault
bus_err  out  1  qualifies wb_valid: timeout fault

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs are 0, including wb_*, mem_*, misaligned and bus_err. Timeout counter=0.
- States: IDLE, REQ, WAIT. stall is combinational from state.
- Accept occurs in IDLE when ex_valid=1. Operand fields are latched on accept.
- Non-memory op (mem_read=mem_write=0): next cycle wb_valid=1, wb_data=alu_y, wb_we=(rd!=0). Latency 1, no stall.
- Both mem_read and mem_write set: treat as a store.
- Alignment: H requires alu_y[0]==0; W requires alu_y[1:0]==0. On misalignment: no bus request; next cycle wb_valid=1, misaligned=1, wb_we=0.
- Aligned memory op: transition to REQ.
  - mem_be: B = 1<<a[1:0]; H = 4'b0011<<a[1:0]; W = 4'b1111.
  - mem_wdata: B = {4{rdd2[7:0]}}; H = {2{rdd2[15:0]}}; W = rdd2.
  - mem_we = store.
- REQ: mem_req=1 and all mem_* held stable until mem_gnt=1.
  - Store with gnt: next cycle wb_valid=1, wb_we=0; go to IDLE.
  - Load with gnt: mem_req drops next cycle; go to WAIT.
- WAIT: on mem_rvalid, extract the lane by the latched a[1:0]. Sign-extend if funct3[2]==0, else zero-extend. Next cycle wb_valid=1, wb_data=extended value, wb_we=(rd!=0); go to IDLE. rvalid can arrive earliest the cycle after gnt.
- mem_rvalid in IDLE or REQ is ignored.
- Timeout: counter clears on entry to REQ and increments each REQ/WAIT cycle. At TIMEOUT, next cycle wb_valid=1, bus_err=1, wb_we=0, mem_req=0; go to IDLE.
- wb_valid, misaligned and bus_err are single-cycle pulses. When the state returns to IDLE, stall deasserts in the same cycle wb_valid is high, and the next instruction may be accepted in that cycle.
- Reset mid-transaction: the transaction is abandoned. mem_req=0 from the cycle after reset is sampled. Late rvalid is ignored.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, REQ, WAIT}
  - size constants LS_B=2'b00, LS_H=2'b01, LS_W=2'b10
  - TIMEOUT counter width
- Sub-module lsu_load_align: combinational lane select plus sign/zero extend (inputs: rdata, offset, funct3).

Test Plan:
- Non-memory op: alu_y=32'h1234, rd=5 -> next cycle wb_valid=1, wb_data=32'h1234, wb_we=1, stall=0; the same op with rd=0 -> wb_we=0.
- Store byte: alu_y=32'h1003, rdd2=32'hAB, gnt held low 2 cycles -> mem_addr=32'h1000, mem_be=4'b1000, mem_wdata=32'hABABABAB stable for 3 cycles; wb_valid 1 cycle after gnt, with wb_we=0.
- Signed load half: alu_y=32'h2002, rdata=32'h8001_0000, rvalid 3 cycles after gnt -> wb_data=32'hFFFF8001; with funct3=101 -> 32'h00008001; stall=1 throughout the transaction.
- Misaligned word load: alu_y=32'h3001 -> mem_req never asserted; next cycle wb_valid=1, misaligned=1, wb_we=0.
- Timeout: request with gnt held low for TIMEOUT cycles -> bus_err=1 with wb_valid, mem_req=0, stall=0 afterwards.
- Reset in WAIT, then stray rvalid -> all outputs 0, state IDLE, no wb_valid.
